mat_dma: RTL
============

MAT_DMA -- requirements
Module: mat_dma

Interface
REQ-001 Parameter: MEM_WORDS, 101, number of 32-bit words in the attached tile memory.
REQ-002 Parameter: TILE_WORDS, 16, words per 4x4 tile, fixed, row-major.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_write  in  1  1 = store tile to memory, 0 = load tile from memory.
REQ-008 cmd_addr  in  8  tile base word address.
REQ-009 wr_data / wr_valid / wr_ready  in 32 / in 1 / out 1  word-serial tile input stream.
REQ-010 rd_data / rd_valid / rd_ready  out 32 / out 1 / in 1  word-serial tile output stream.
REQ-011 done  out  1  one-cycle pulse at command completion.
REQ-012 err  out  1  one-cycle pulse on rejected command.
REQ-013 mem_read / mem_write  out 1 / out 1  tile memory strobes.
REQ-014 mem_addr  out  8  tile memory base address.
REQ-015 mem_wdata  out  512  tile to memory; word k (k = row*4+col) at bits [32k+31:32k].
REQ-016 mem_rdata  in  512  tile from memory, same packing; valid the cycle after the mem_read cycle.

Function
REQ-017 FSM states: IDLE, GATHER, WRITE, READ, CAPTURE, STREAM.
REQ-018 IDLE: cmd_ready=1; all other outputs 0 except mem_addr and mem_wdata, which hold their last values.
REQ-019 On accept with cmd_addr+15 > MEM_WORDS-1 (cmd_addr > 85): err pulses in the next cycle; FSM stays in IDLE; no memory strobe.
REQ-020 On accept of a legal command: cmd_addr is latched into mem_addr; write -> GATHER, read -> READ; word counter is cleared to 0.
REQ-021 GATHER: wr_ready=1; each wr_valid&&wr_ready handshake stores wr_data into word slot [counter] of mem_wdata and increments the counter.
REQ-022 GATHER: after the 16th handshake (counter 15) the FSM moves to WRITE; wr_ready=0 in the following cycle.
REQ-023 WRITE: mem_write=1 for exactly one cycle; mem_wdata and mem_addr are stable during it; done pulses in that same cycle; next state is IDLE.
REQ-024 READ: mem_read=1 for exactly one cycle; next state is CAPTURE.
REQ-025 CAPTURE: mem_rdata is latched into an internal 16-word buffer at the end of the cycle; next state is STREAM with counter 0.
REQ-026 STREAM: rd_valid=1; rd_data=buffer[counter].
REQ-027 STREAM stall: rd_data and rd_valid hold unchanged while rd_ready=0.
REQ-028 STREAM: each handshake increments the counter; on the 16th handshake done pulses in that cycle and the next state is IDLE.
REQ-029 mem_read and mem_write are never high in the same cycle; neither is high outside the READ or WRITE state.
REQ-030 cmd_valid outside IDLE is ignored (not accepted); wr_valid outside GATHER and rd_ready outside STREAM are ignored.
REQ-031 Minimum latency: write command = 16 data cycles + 1 WRITE cycle; read command = READ + CAPTURE + 16 stream cycles.
REQ-032 The 4-bit word counter does not wrap within a command; it is cleared on every accept.

Reset
REQ-033 rst high at a clock edge: state=IDLE, counter=0, cmd_ready=1 in the next cycle; wr_ready, rd_valid, done, err, mem_read, mem_write=0; mem_addr=0; mem_wdata=0; rd_data=0.
REQ-034 rst asserted mid-GATHER or mid-STREAM discards the partial tile; no mem_write follows and done does not pulse.

Verification
REQ-035 Store: write cmd at addr 0x10 with words 0x100..0x10F, back-to-back -> mem_write high exactly one cycle, mem_addr=0x10, mem_wdata word k=0x100+k, done in the same cycle.
REQ-036 Load with backpressure: read cmd at addr 0x10, rd_ready toggling 1/0 -> 16 words 0x100..0x10F in order, each held stable while stalled; done on the 16th handshake.
REQ-037 Bounds: cmd_addr=85 accepted; cmd_addr=86 -> err pulse, no strobe, cmd_ready=1 in the next cycle.
REQ-038 Gapped input: wr_valid asserted every third cycle -> exactly 16 words captured; mem_write occurs only after the 16th.
REQ-039 Reset mid-GATHER after 7 words -> no mem_write; a subsequent full store at addr 0 writes only the new 16 words.
REQ-040 cmd_valid held high during STREAM -> not accepted until IDLE; mem_read and mem_write are never both high (assertion).

Source files
------------

// File: rtl/mat_dma.sv
// mat_dma: moves 4x4 tiles of 32-bit words between word streams and a
// 512-bit-wide tile memory port, one tile per command.
module mat_dma #(
    parameter int MEM_WORDS  = 101,
    parameter int TILE_WORDS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [7:0]                 cmd_addr,
    input  logic [31:0]                wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [31:0]                rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic                       done,
    output logic                       err,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [7:0]                 mem_addr,
    output logic [TILE_WORDS*32-1:0]   mem_wdata,
    input  logic [TILE_WORDS*32-1:0]   mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        GATHER,
        WRITE,
        READ,
        CAPTURE,
        STREAM
    } state_t;

    localparam logic [8:0] LAST_WORD = 9'(MEM_WORDS - 1);
    localparam logic [8:0] SPAN      = 9'(TILE_WORDS - 1);
    localparam logic [3:0] CNT_LAST  = 4'(TILE_WORDS - 1);

    state_t                     state;
    logic [3:0]                 cnt;
    logic [TILE_WORDS*32-1:0]   rbuf;
    logic [8:0]                 end_addr;
    logic                       out_of_range;
    logic                       rd_fire;

    // Last word touched by the tile must still lie inside the memory.
    assign end_addr     = {1'b0, cmd_addr} + SPAN;
    assign out_of_range = end_addr > LAST_WORD;
    assign rd_fire      = (state == STREAM) && rd_ready;

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == GATHER);
    assign rd_valid  = (state == STREAM);
    assign mem_write = (state == WRITE);
    assign mem_read  = (state == READ);
    assign rd_data   = rd_valid ? rbuf[{cnt, 5'd0} +: 32] : '0;
    assign done      = mem_write || (rd_fire && cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rbuf      <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (out_of_range) begin
                            err <= 1'b1;
                        end else begin
                            mem_addr <= cmd_addr;
                            cnt      <= '0;
                            state    <= cmd_write ? GATHER : READ;
                        end
                    end
                end
                GATHER: begin
                    if (wr_valid) begin
                        mem_wdata[{cnt, 5'd0} +: 32] <= wr_data;
                        cnt <= cnt + 4'd1;
                        if (cnt == CNT_LAST) state <= WRITE;
                    end
                end
                WRITE:   state <= IDLE;
                READ:    state <= CAPTURE;
                CAPTURE: begin
                    rbuf  <= mem_rdata;
                    cnt   <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (rd_ready) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == CNT_LAST) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
